// File: rtl/int_ctrl_prio.sv
// Machine-mode interrupt/exception controller with fixed-priority external sources.
// Latches edge/level interrupt lines, arbitrates lowest-index-first, and sequences the
// mepc/mcause/mstatus CSR writes for trap entry as well as the mstatus write for mret.
module int_ctrl_prio #(
  parameter int unsigned          NUM_SRC    = 16,
  parameter logic [NUM_SRC-1:0]   EDGE_MASK  = {NUM_SRC{1'b1}},
  parameter bit                   VECTORED   = 1'b1,
  parameter int unsigned          CAUSE_BASE = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] irq_i,
  input  logic [NUM_SRC-1:0] irq_en_i,
  input  logic               global_int_en_i,
  input  logic [31:0]        inst_i,
  input  logic [31:0]        inst_addr_i,
  input  logic               branch_flag_i,
  input  logic [31:0]        branch_addr_i,
  input  logic               div_i,
  input  logic [31:0]        csr_mtvec,
  input  logic [31:0]        csr_mepc,
  input  logic [31:0]        csr_mstatus,
  output logic               we_o,
  output logic [31:0]        waddr_o,
  output logic [31:0]        data_o,
  output logic               int_assert_o,
  output logic [31:0]        int_addr_o,
  output logic               irq_claim_o,
  output logic [4:0]         claim_id_o,
  output logic               stallreq_o
);

  localparam logic [31:0] InstEcall  = 32'h0000_0073;
  localparam logic [31:0] InstEbreak = 32'h0010_0073;
  localparam logic [31:0] InstMret   = 32'h3020_0073;

  localparam logic [31:0] CsrMstatus = 32'h0000_0300;
  localparam logic [31:0] CsrMepc    = 32'h0000_0341;
  localparam logic [31:0] CsrMcause  = 32'h0000_0342;

  typedef enum logic [2:0] {StIdle, StMepc, StMcause, StMstatus, StMret} state_e;

  state_e state_q, state_d;

  logic [NUM_SRC-1:0] irq_prev_q;
  logic [NUM_SRC-1:0] pend_edge_q, pend_edge_d;
  logic [NUM_SRC-1:0] claim_clr;
  logic [NUM_SRC-1:0] pending, req;
  logic [4:0]         win_id;
  logic               req_any;

  logic        sync_det, async_det, mret_det, event_det;
  logic        is_ecall, is_ebreak, is_mret;
  logic [31:0] async_epc;
  logic [31:0] target;

  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [4:0]  id_q, id_d;
  logic        async_q, async_d;
  logic        in_trap_q, in_trap_d;
  logic        branch_flag_q;
  logic [31:0] branch_addr_q;

  logic        we_q, we_d;
  logic [31:0] waddr_q, waddr_d;
  logic [31:0] data_q, data_d;
  logic        int_assert_q, int_assert_d;
  logic [31:0] int_addr_q, int_addr_d;
  logic        claim_q, claim_d;
  logic [4:0]  claim_id_q, claim_id_d;

  // Pending bookkeeping: edge sources are stored, level sources follow the line directly.
  always_comb begin
    claim_clr = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (claim_q && (claim_id_q == 5'(i))) claim_clr[i] = 1'b1;
    end
    // A new edge in the claim cycle must not be lost, so set wins over clear.
    pend_edge_d = (pend_edge_q & ~claim_clr) | (irq_i & ~irq_prev_q & EDGE_MASK);
    pending     = (pend_edge_q & EDGE_MASK) | (irq_i & ~EDGE_MASK);
    req         = pending & irq_en_i;
  end

  // Fixed-priority arbiter: lowest set index wins.
  always_comb begin
    req_any = |req;
    win_id  = '0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (req[i]) win_id = 5'(i);
    end
  end

  // Event detection, only evaluated while idle; synchronous traps beat interrupts.
  always_comb begin
    is_ecall  = (inst_i == InstEcall);
    is_ebreak = (inst_i == InstEbreak);
    is_mret   = (inst_i == InstMret);
    sync_det  = (state_q == StIdle) && (is_ecall || is_ebreak) && !div_i && !in_trap_q;
    async_det = (state_q == StIdle) && !sync_det && req_any && global_int_en_i && !in_trap_q;
    mret_det  = (state_q == StIdle) && !sync_det && !async_det && is_mret;
    event_det = sync_det || async_det || mret_det;

    // Interrupted instruction: a taken branch (now or last cycle) redirects the return
    // point; a busy divider means the current PC already moved past the divide.
    if (branch_flag_i) begin
      async_epc = branch_addr_i;
    end else if (branch_flag_q) begin
      async_epc = branch_addr_q;
    end else if (div_i) begin
      async_epc = inst_addr_i - 32'd4;
    end else begin
      async_epc = inst_addr_i;
    end

    if (VECTORED && (csr_mtvec[1:0] == 2'b01) && async_q) begin
      target = {csr_mtvec[31:2], 2'b00} + ((CAUSE_BASE + 32'(id_q)) << 2);
    end else begin
      target = {csr_mtvec[31:2], 2'b00};
    end
  end

  // Trap sequencer: next state, latched trap info and next-cycle output values.
  always_comb begin
    state_d      = state_q;
    cause_d      = cause_q;
    epc_d        = epc_q;
    id_d         = id_q;
    async_d      = async_q;
    in_trap_d    = in_trap_q;
    we_d         = 1'b0;
    waddr_d      = '0;
    data_d       = '0;
    int_assert_d = 1'b0;
    int_addr_d   = '0;
    claim_d      = 1'b0;
    claim_id_d   = '0;

    case (state_q)
      StIdle: begin
        if (sync_det) begin
          state_d   = StMepc;
          cause_d   = is_ecall ? 32'd11 : 32'd3;
          epc_d     = inst_addr_i;
          id_d      = win_id;
          async_d   = 1'b0;
          in_trap_d = 1'b1;
        end else if (async_det) begin
          state_d   = StMepc;
          cause_d   = {1'b1, 31'(CAUSE_BASE + 32'(win_id))};
          epc_d     = async_epc;
          id_d      = win_id;
          async_d   = 1'b1;
          in_trap_d = 1'b1;
        end else if (mret_det) begin
          state_d = StMret;
        end
      end
      StMepc: begin
        state_d = StMcause;
        we_d    = 1'b1;
        waddr_d = CsrMepc;
        data_d  = epc_q;
      end
      StMcause: begin
        state_d      = StMstatus;
        we_d         = 1'b1;
        waddr_d      = CsrMcause;
        data_d       = cause_q;
        int_assert_d = 1'b1;
        int_addr_d   = target;
        claim_d      = async_q;
        claim_id_d   = async_q ? id_q : 5'd0;
      end
      StMstatus: begin
        state_d   = StIdle;
        we_d      = 1'b1;
        waddr_d   = CsrMstatus;
        data_d    = csr_mstatus;
        data_d[7] = csr_mstatus[3];
        data_d[3] = 1'b0;
      end
      StMret: begin
        state_d      = StIdle;
        we_d         = 1'b1;
        waddr_d      = CsrMstatus;
        data_d       = csr_mstatus;
        data_d[3]    = csr_mstatus[7];
        data_d[7]    = 1'b1;
        int_assert_d = 1'b1;
        int_addr_d   = csr_mepc;
        in_trap_d    = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, trap info and registered outputs; reset aborts any sequence in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      irq_prev_q    <= '0;
      pend_edge_q   <= '0;
      cause_q       <= '0;
      epc_q         <= '0;
      id_q          <= '0;
      async_q       <= 1'b0;
      in_trap_q     <= 1'b0;
      branch_flag_q <= 1'b0;
      branch_addr_q <= '0;
      we_q          <= 1'b0;
      waddr_q       <= '0;
      data_q        <= '0;
      int_assert_q  <= 1'b0;
      int_addr_q    <= '0;
      claim_q       <= 1'b0;
      claim_id_q    <= '0;
    end else begin
      state_q       <= state_d;
      irq_prev_q    <= irq_i;
      pend_edge_q   <= pend_edge_d;
      cause_q       <= cause_d;
      epc_q         <= epc_d;
      id_q          <= id_d;
      async_q       <= async_d;
      in_trap_q     <= in_trap_d;
      branch_flag_q <= branch_flag_i;
      branch_addr_q <= branch_addr_i;
      we_q          <= we_d;
      waddr_q       <= waddr_d;
      data_q        <= data_d;
      int_assert_q  <= int_assert_d;
      int_addr_q    <= int_addr_d;
      claim_q       <= claim_d;
      claim_id_q    <= claim_id_d;
    end
  end

  assign we_o         = we_q;
  assign waddr_o      = waddr_q;
  assign data_o       = data_q;
  assign int_assert_o = int_assert_q;
  assign int_addr_o   = int_addr_q;
  assign irq_claim_o  = claim_q;
  assign claim_id_o   = claim_id_q;
  // Hold the pipeline from detection until the last CSR write has left.
  assign stallreq_o   = event_det || (state_q != StIdle) || we_q;

endmodule

// File: tb/tb_int_ctrl_prio.sv
// Scoreboard bench for int_ctrl_prio: stimulus pushes expected CSR-write beats, a monitor
// pops and compares them whenever the controller drives an output.
module tb_int_ctrl_prio;

  localparam int unsigned NumSrc = 16;
  localparam logic [31:0] Nop    = 32'h0000_0013;
  localparam logic [31:0] Ecall  = 32'h0000_0073;
  localparam logic [31:0] Mret   = 32'h3020_0073;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NumSrc-1:0] irq_i = '0;
  logic [NumSrc-1:0] irq_en_i = '1;
  logic              global_int_en_i = 1'b1;
  logic [31:0]       inst_i = Nop;
  logic [31:0]       inst_addr_i = 32'h0;
  logic              branch_flag_i = 1'b0;
  logic [31:0]       branch_addr_i = 32'h0;
  logic              div_i = 1'b0;
  logic [31:0]       csr_mtvec = 32'h200;
  logic [31:0]       csr_mepc = 32'h0;
  logic [31:0]       csr_mstatus = 32'h88;

  logic        we_o, int_assert_o, irq_claim_o, stallreq_o;
  logic [31:0] waddr_o, data_o, int_addr_o;
  logic [4:0]  claim_id_o;

  logic        nv_we, nv_int_assert, nv_claim, nv_stall;
  logic [31:0] nv_waddr, nv_data, nv_int_addr;
  logic [4:0]  nv_claim_id;

  typedef struct packed {
    logic [31:0] waddr;
    logic [31:0] data;
    logic        asrt;
    logic [31:0] addr;
    logic        claim;
    logic [4:0]  id;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] nv_q[$];
  beat_t       exp_b;
  logic [31:0] exp_nv;
  int          n_checks = 0;
  int          n_pass = 0;

  int_ctrl_prio u_dut (
    .clk(clk), .rst_n(rst_n), .irq_i(irq_i), .irq_en_i(irq_en_i),
    .global_int_en_i(global_int_en_i), .inst_i(inst_i), .inst_addr_i(inst_addr_i),
    .branch_flag_i(branch_flag_i), .branch_addr_i(branch_addr_i), .div_i(div_i),
    .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc), .csr_mstatus(csr_mstatus),
    .we_o(we_o), .waddr_o(waddr_o), .data_o(data_o), .int_assert_o(int_assert_o),
    .int_addr_o(int_addr_o), .irq_claim_o(irq_claim_o), .claim_id_o(claim_id_o),
    .stallreq_o(stallreq_o)
  );

  int_ctrl_prio #(.VECTORED(1'b0)) u_dut_nv (
    .clk(clk), .rst_n(rst_n), .irq_i(irq_i), .irq_en_i(irq_en_i),
    .global_int_en_i(global_int_en_i), .inst_i(inst_i), .inst_addr_i(inst_addr_i),
    .branch_flag_i(branch_flag_i), .branch_addr_i(branch_addr_i), .div_i(div_i),
    .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc), .csr_mstatus(csr_mstatus),
    .we_o(nv_we), .waddr_o(nv_waddr), .data_o(nv_data), .int_assert_o(nv_int_assert),
    .int_addr_o(nv_int_addr), .irq_claim_o(nv_claim), .claim_id_o(nv_claim_id),
    .stallreq_o(nv_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input bit ok, input string act, input string exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %s, expected %s", name, act, exp);
  endtask

  function automatic string fmt(input logic we, input logic [31:0] a, input logic [31:0] d,
                                input logic ia, input logic [31:0] ta, input logic c,
                                input logic [4:0] id);
    return $sformatf("we=%0b waddr=%h data=%h assert=%0b addr=%h claim=%0b id=%0d",
                     we, a, d, ia, ta, c, id);
  endfunction

  // Monitor: every output beat must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (we_o || int_assert_o || irq_claim_o) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 1'b0, fmt(we_o, waddr_o, data_o, int_assert_o,
              int_addr_o, irq_claim_o, claim_id_o), "no output");
        end else begin
          exp_b = exp_q.pop_front();
          chk("csr_beat", we_o && waddr_o == exp_b.waddr && data_o == exp_b.data &&
              int_assert_o == exp_b.asrt && int_addr_o == exp_b.addr &&
              irq_claim_o == exp_b.claim && claim_id_o == exp_b.id,
              fmt(we_o, waddr_o, data_o, int_assert_o, int_addr_o, irq_claim_o, claim_id_o),
              fmt(1'b1, exp_b.waddr, exp_b.data, exp_b.asrt, exp_b.addr, exp_b.claim,
                  exp_b.id));
        end
      end
      if (nv_int_assert) begin
        if (nv_q.size() == 0) begin
          chk("nv_unexpected_redirect", 1'b0, $sformatf("%h", nv_int_addr), "none");
        end else begin
          exp_nv = nv_q.pop_front();
          chk("nv_target", nv_int_addr == exp_nv, $sformatf("%h", nv_int_addr),
              $sformatf("%h", exp_nv));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    for (int i = 0; i < 60 && stallreq_o; i++) step();
    if (stallreq_o) chk("settle_timeout", 1'b0, "stall held", "stall released");
  endtask

  task automatic push_trap(input logic [31:0] epc, input logic [31:0] cause,
                           input logic [31:0] tv, input logic [31:0] tnv, input logic claim,
                           input logic [4:0] id, input logic [31:0] mst);
    exp_q.push_back('{waddr: 32'h341, data: epc, asrt: 1'b0, addr: 32'h0, claim: 1'b0,
                      id: 5'd0});
    exp_q.push_back('{waddr: 32'h342, data: cause, asrt: 1'b1, addr: tv, claim: claim,
                      id: id});
    exp_q.push_back('{waddr: 32'h300, data: mst, asrt: 1'b0, addr: 32'h0, claim: 1'b0,
                      id: 5'd0});
    nv_q.push_back(tnv);
  endtask

  // mret with mstatus 0x80 (MPIE=1, MIE=0) must write back 0x88.
  task automatic push_mret(input logic [31:0] mepc);
    csr_mepc    = mepc;
    csr_mstatus = 32'h80;
    exp_q.push_back('{waddr: 32'h300, data: 32'h88, asrt: 1'b1, addr: mepc, claim: 1'b0,
                      id: 5'd0});
    nv_q.push_back(mepc);
  endtask

  task automatic issue(input logic [31:0] inst, input logic [31:0] pc);
    inst_i      = inst;
    inst_addr_i = pc;
    step();
    inst_i = Nop;
  endtask

  task automatic do_mret(input logic [31:0] mepc);
    push_mret(mepc);
    issue(Mret, mepc);
    settle();
    csr_mstatus = 32'h88;
  endtask

  task automatic chk_idle(input string name);
    chk(name, !we_o && waddr_o == 0 && data_o == 0 && !int_assert_o && int_addr_o == 0 &&
        !irq_claim_o && claim_id_o == 0 && !stallreq_o,
        $sformatf("%s stall=%0b", fmt(we_o, waddr_o, data_o, int_assert_o, int_addr_o,
                  irq_claim_o, claim_id_o), stallreq_o), "all zero");
  endtask

  initial begin
    #3;
    chk_idle("reset_outputs");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    chk_idle("idle_after_reset");

    // ECALL at 0x100, direct mtvec 0x200.
    push_trap(32'h100, 32'd11, 32'h200, 32'h200, 1'b0, 5'd0, 32'h80);
    issue(Ecall, 32'h100);
    settle();
    do_mret(32'h104);

    // Sources 3 and 5 together: 3 first, 5 taken right after mret.
    inst_addr_i = 32'h300;
    push_trap(32'h300, 32'h8000_0013, 32'h200, 32'h200, 1'b1, 5'd3, 32'h80);
    irq_i = 16'h0028;
    step();
    irq_i = '0;
    settle();
    push_mret(32'h300);
    push_trap(32'h300, 32'h8000_0015, 32'h200, 32'h200, 1'b1, 5'd5, 32'h00);
    issue(Mret, 32'h300);
    settle();
    do_mret(32'h300);

    // Vectored mode, source 2.
    csr_mtvec   = 32'h1001;
    inst_addr_i = 32'h500;
    push_trap(32'h500, 32'h8000_0012, 32'h1048, 32'h1000, 1'b1, 5'd2, 32'h80);
    irq_i = 16'h0004;
    step();
    irq_i = '0;
    settle();
    do_mret(32'h500);
    csr_mtvec = 32'h200;

    // ECALL coincides with source 0: sync first, source 0 after mret.
    push_trap(32'h600, 32'd11, 32'h200, 32'h200, 1'b0, 5'd0, 32'h80);
    irq_i = 16'h0001;
    step();
    irq_i = '0;
    issue(Ecall, 32'h600);
    settle();
    push_mret(32'h604);
    push_trap(32'h604, 32'h8000_0010, 32'h200, 32'h200, 1'b1, 5'd0, 32'h00);
    issue(Mret, 32'h604);
    settle();
    do_mret(32'h604);

    // Branch taken in the detection cycle.
    inst_addr_i = 32'h700;
    push_trap(32'h400, 32'h8000_0011, 32'h200, 32'h200, 1'b1, 5'd1, 32'h80);
    irq_i = 16'h0002;
    step();
    irq_i         = '0;
    branch_flag_i = 1'b1;
    branch_addr_i = 32'h400;
    step();
    branch_flag_i = 1'b0;
    settle();
    do_mret(32'h400);

    // Branch taken the cycle before detection.
    inst_addr_i = 32'h700;
    push_trap(32'h444, 32'h8000_0011, 32'h200, 32'h200, 1'b1, 5'd1, 32'h80);
    irq_i         = 16'h0002;
    branch_flag_i = 1'b1;
    branch_addr_i = 32'h444;
    step();
    irq_i         = '0;
    branch_flag_i = 1'b0;
    branch_addr_i = 32'h999;
    settle();
    do_mret(32'h444);

    // Divider busy: return to PC - 4.
    push_trap(32'h7C, 32'h8000_0011, 32'h200, 32'h200, 1'b1, 5'd1, 32'h80);
    irq_i = 16'h0002;
    step();
    irq_i       = '0;
    div_i       = 1'b1;
    inst_addr_i = 32'h80;
    step();
    div_i = 1'b0;
    settle();
    do_mret(32'h7C);

    // Reset while in MCAUSE: nothing more may be written, pending 6 must be gone.
    irq_i = 16'h0050;
    step();
    irq_i = '0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk_idle("abort_outputs");
    step();
    step();
    chk_idle("abort_held");
    rst_n = 1'b1;
    repeat (12) step();
    chk_idle("after_abort_idle");

    chk("expected_beats_drained", exp_q.size() == 0, $sformatf("%0d left", exp_q.size()),
        "0 left");
    chk("nv_targets_drained", nv_q.size() == 0, $sformatf("%0d left", nv_q.size()),
        "0 left");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
